// File: rtl/hht_csr_sequencer.sv
// CSR fetch sequencer: walks row pointers, column indices, matrix values and the
// dense vector over two shared read ports, emitting one (row, mval, vval) beat per nonzero.
module hht_csr_sequencer #(
    parameter int unsigned N_ROWS = 16,
    parameter int unsigned N_COLS = 16,
    localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [31:0]   row_base,
    input  logic [31:0]   wdata_col_base,
    input  logic [31:0]   matrix_base,
    input  logic [31:0]   v_values_base,
    input  logic [31:0]   csize,
    output logic [31:0]   addr1,
    input  logic [31:0]   dataIn1,
    output logic [31:0]   addr2,
    input  logic [31:0]   dataIn2,
    output logic          elem_valid,
    input  logic          elem_ready,
    output logic [RW-1:0] elem_row,
    output logic [31:0]   elem_mval,
    output logic [31:0]   elem_vval,
    output logic          elem_last,
    output logic          elem_empty,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, RP0, RP1, COL, VEC, OUT, DONE} state_t;

    state_t        state, state_d;
    logic [31:0]   rb_q, cb_q, mb_q, vb_q, csize_q, p_start_q, p_end_q, k_q, mval_q;
    logic [31:0]   rb_d, cb_d, mb_d, vb_d, csize_d, p_start_d, p_end_d, k_d, mval_d;
    logic [RW-1:0] row_q, row_d;
    logic [31:0]   addr1_d, addr2_d, elem_mval_d, elem_vval_d;
    logic [RW-1:0] elem_row_d;
    logic          elem_valid_d, elem_last_d, elem_empty_d, busy_d, done_d, err_d;
    logic [31:0]   p_end_clamp;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state;
        rb_d         = rb_q;
        cb_d         = cb_q;
        mb_d         = mb_q;
        vb_d         = vb_q;
        csize_d      = csize_q;
        p_start_d    = p_start_q;
        p_end_d      = p_end_q;
        k_d          = k_q;
        mval_d       = mval_q;
        row_d        = row_q;
        addr1_d      = addr1;
        addr2_d      = addr2;
        elem_row_d   = elem_row;
        elem_mval_d  = elem_mval;
        elem_vval_d  = elem_vval;
        elem_last_d  = elem_last;
        elem_empty_d = elem_empty;
        err_d        = err;
        p_end_clamp  = (dataIn1 > csize_q) ? csize_q : dataIn1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RP0;
                    rb_d    = row_base;
                    cb_d    = wdata_col_base;
                    mb_d    = matrix_base;
                    vb_d    = v_values_base;
                    csize_d = csize;
                    row_d   = '0;
                    err_d   = 1'b0;
                    addr1_d = row_base;
                end
            end
            RP0: begin
                p_start_d = dataIn1;
                addr1_d   = rb_q + 32'(row_q) + 32'd1;
                state_d   = RP1;
            end
            RP1: begin
                p_end_d = p_end_clamp;
                k_d     = p_start_q;
                if ((dataIn1 > csize_q) || (p_end_clamp < p_start_q)) err_d = 1'b1;
                if (p_end_clamp <= p_start_q) begin
                    state_d      = OUT;
                    elem_row_d   = row_q;
                    elem_mval_d  = '0;
                    elem_vval_d  = '0;
                    elem_last_d  = 1'b1;
                    elem_empty_d = 1'b1;
                end else begin
                    state_d = COL;
                    addr1_d = cb_q + p_start_q;
                    addr2_d = mb_q + p_start_q;
                end
            end
            COL: begin
                mval_d = dataIn2;
                // Out-of-range column: skip the vector fetch but still emit the beat
                if (dataIn1 >= 32'(N_COLS)) begin
                    err_d        = 1'b1;
                    state_d      = OUT;
                    elem_row_d   = row_q;
                    elem_mval_d  = dataIn2;
                    elem_vval_d  = '0;
                    elem_last_d  = ((k_q + 32'd1) == p_end_q);
                    elem_empty_d = 1'b0;
                end else begin
                    addr2_d = vb_q + dataIn1;
                    state_d = VEC;
                end
            end
            VEC: begin
                state_d      = OUT;
                elem_row_d   = row_q;
                elem_mval_d  = mval_q;
                elem_vval_d  = dataIn2;
                elem_last_d  = ((k_q + 32'd1) == p_end_q);
                elem_empty_d = 1'b0;
            end
            OUT: begin
                if (elem_ready) begin
                    if (!elem_last) begin
                        k_d     = k_q + 32'd1;
                        addr1_d = cb_q + k_q + 32'd1;
                        addr2_d = mb_q + k_q + 32'd1;
                        state_d = COL;
                    end else if (row_q == RW'(N_ROWS - 1)) begin
                        state_d = DONE;
                    end else begin
                        // Previous row's end pointer is this row's start: no re-read
                        row_d     = row_q + RW'(1);
                        p_start_d = p_end_q;
                        addr1_d   = rb_q + 32'(row_q) + 32'd2;
                        state_d   = RP1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        elem_valid_d = (state_d == OUT);
        done_d       = (state == DONE);
        busy_d       = (state_d != IDLE) || (state == DONE);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            rb_q       <= '0;
            cb_q       <= '0;
            mb_q       <= '0;
            vb_q       <= '0;
            csize_q    <= '0;
            p_start_q  <= '0;
            p_end_q    <= '0;
            k_q        <= '0;
            mval_q     <= '0;
            row_q      <= '0;
            addr1      <= '0;
            addr2      <= '0;
            elem_valid <= 1'b0;
            elem_row   <= '0;
            elem_mval  <= '0;
            elem_vval  <= '0;
            elem_last  <= 1'b0;
            elem_empty <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            rb_q       <= rb_d;
            cb_q       <= cb_d;
            mb_q       <= mb_d;
            vb_q       <= vb_d;
            csize_q    <= csize_d;
            p_start_q  <= p_start_d;
            p_end_q    <= p_end_d;
            k_q        <= k_d;
            mval_q     <= mval_d;
            row_q      <= row_d;
            addr1      <= addr1_d;
            addr2      <= addr2_d;
            elem_valid <= elem_valid_d;
            elem_row   <= elem_row_d;
            elem_mval  <= elem_mval_d;
            elem_vval  <= elem_vval_d;
            elem_last  <= elem_last_d;
            elem_empty <= elem_empty_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_hht_csr_sequencer.sv
// Directed bench for hht_csr_sequencer: sparse memory model on both read ports,
// beat capture per pass, and expected beat lists built by hand for each matrix.
module tb_hht_csr_sequencer;

    typedef logic [69:0] beat_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] row_base = '0, wdata_col_base = '0, matrix_base = '0, v_values_base = '0, csize = '0;
    logic [31:0] addr1, addr2, dataIn1, dataIn2;
    logic        elem_valid, elem_last, elem_empty, busy, done, err;
    logic        elem_ready = 1'b1;
    logic [3:0]  elem_row;
    logic [31:0] elem_mval, elem_vval;

    logic [31:0] mem [0:131071];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    beat_t       got[$];
    beat_t       exp_q[$];
    int          nnz_tab [16] = '{2, 1, 0, 3, 1, 0, 2, 1, 1, 0, 2, 1, 2, 1, 1, 2};

    assign dataIn1 = mem[addr1[16:0]];
    assign dataIn2 = mem[addr2[16:0]];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    hht_csr_sequencer #(.N_ROWS(16), .N_COLS(16)) dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .row_base(row_base), .wdata_col_base(wdata_col_base),
        .matrix_base(matrix_base), .v_values_base(v_values_base), .csize(csize),
        .addr1(addr1), .dataIn1(dataIn1), .addr2(addr2), .dataIn2(dataIn2),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_row(elem_row),
        .elem_mval(elem_mval), .elem_vval(elem_vval), .elem_last(elem_last),
        .elem_empty(elem_empty), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t mk(input int r, input logic [31:0] m, input logic [31:0] v,
                                 input logic l, input logic e);
        return {4'(r), m, v, l, e};
    endfunction

    function automatic beat_t cur();
        return {elem_row, elem_mval, elem_vval, elem_last, elem_empty};
    endfunction

    function automatic logic [159:0] outs();
        return 160'({addr1, addr2, elem_valid, elem_row, elem_mval, elem_vval,
                     elem_last, elem_empty, busy, done, err});
    endfunction

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = '0;
    endtask

    task automatic set_bases(input logic [31:0] rb, cb, mb, vb, cs);
        row_base = rb; wdata_col_base = cb; matrix_base = mb; v_values_base = vb; csize = cs;
    endtask

    // Basic matrix: row0 = {(col0,31),(col5,32)}, rows 1..15 empty
    task automatic setup_basic();
        clear_mem();
        mem[31550] = 0;
        for (int r = 1; r <= 16; r++) mem[31550 + r] = 2;
        mem[2950] = 0;  mem[2951] = 5;
        mem[90] = 31;   mem[91] = 32;
        mem[2] = 82;    mem[7] = 93;
        set_bases(31550, 2950, 90, 2, 2);
        exp_q.delete();
        exp_q.push_back(mk(0, 31, 82, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 32, 93, 1'b1, 1'b0));
        for (int r = 1; r < 16; r++) exp_q.push_back(mk(r, 0, 0, 1'b1, 1'b1));
    endtask

    // 16x16 matrix with 20 nonzeros; column of nonzero k is (3k mod 16)
    task automatic setup_full();
        int p;
        clear_mem();
        p = 0;
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            mem[4000 + r] = p;
            if (nnz_tab[r] == 0) exp_q.push_back(mk(r, 0, 0, 1'b1, 1'b1));
            for (int j = 0; j < nnz_tab[r]; j++) begin
                mem[5000 + p] = (p * 3) % 16;
                mem[6000 + p] = 100 + p;
                exp_q.push_back(mk(r, 100 + p, 1000 + ((p * 3) % 16), j == nnz_tab[r] - 1, 1'b0));
                p++;
            end
        end
        mem[4016] = p;
        for (int c = 0; c < 16; c++) mem[7000 + c] = 1000 + c;
        set_bases(4000, 5000, 6000, 7000, 20);
    endtask

    // One pass: optional stall of beat stall_beat for stall_len cycles, optional start poke
    task automatic run_pass(input int stall_beat, input int stall_len, input int poke,
                            output int first_v, output int dcyc);
        int    held, idx, c0;
        bit    fin;
        beat_t snap;
        logic [31:0] sa1, sa2;
        got.delete();
        held = 0; idx = 0; fin = 0; dcyc = -1; first_v = -1;
        snap = '0; sa1 = '0; sa2 = '0;
        elem_ready = 1'b1;
        start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 600 && !fin; i++) begin
            if (i > 0) @(negedge Clk);
            start = (poke > 0) && ((cyc - c0) == poke);
            if (done) begin
                dcyc = cyc - c0;
                fin = 1;
                chk("busy_at_done", 160'(busy), 160'(1));
            end else if (elem_valid) begin
                if (first_v < 0) first_v = cyc - c0;
                if (idx == stall_beat && held < stall_len) begin
                    if (held == 0) begin
                        snap = cur(); sa1 = addr1; sa2 = addr2;
                    end else begin
                        chk("stall_hold", 160'({cur(), addr1, addr2}), 160'({snap, sa1, sa2}));
                    end
                    elem_ready = 1'b0;
                    held++;
                end else begin
                    if (held > 0 && idx == stall_beat)
                        chk("stall_release", 160'({cur(), addr1, addr2}), 160'({snap, sa1, sa2}));
                    elem_ready = 1'b1;
                    got.push_back(cur());
                    idx++;
                end
            end
        end
        start = 1'b0;
        elem_ready = 1'b1;
        chk("pass_completed", 160'(fin), 160'(1));
    endtask

    task automatic cmp_beats(input string tag);
        chk({tag, "_count"}, 160'(got.size()), 160'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 160'(got[i]), 160'(exp_q[i]));
    endtask

    initial begin
        int fv, dc;
        bit hit;

        // Reset values
        repeat (2) @(negedge Clk);
        chk("reset_outputs_low", outs(), 160'(0));
        Rst = 1'b1;
        @(negedge Clk);
        chk("idle_outputs", outs(), 160'(0));

        // Basic row with hand-computed beats
        setup_basic();
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("basic");
        chk("basic_first_valid", 160'(fv), 160'(4));
        chk("basic_done_cycles", 160'(dc), 160'(39));
        chk("basic_err", 160'(err), 160'(0));
        @(negedge Clk);
        chk("busy_fall", 160'({busy, done}), 160'(0));

        // Back-pressure on beat 1 for 5 cycles
        setup_basic();
        run_pass(1, 5, 0, fv, dc);
        cmp_beats("stall");
        chk("stall_done_cycles", 160'(dc), 160'(44));
        repeat (2) @(negedge Clk);

        // Full 16x16 pass, 20 nonzeros, 3 empty rows
        setup_full();
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("full");
        chk("full_first_valid", 160'(fv), 160'(4));
        chk("full_done_cycles", 160'(dc), 160'(81));
        chk("full_err", 160'(err), 160'(0));
        repeat (2) @(negedge Clk);

        // start pulsed while busy is ignored
        run_pass(-1, 0, 10, fv, dc);
        cmp_beats("poke");
        chk("poke_done_cycles", 160'(dc), 160'(81));
        repeat (2) @(negedge Clk);
        chk("poke_idle", 160'(busy), 160'(0));

        // Reset in the middle of row 3
        start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge Clk);
            if (elem_valid && elem_row == 4'd3) hit = 1;
        end
        chk("reached_row3", 160'(hit), 160'(1));
        Rst = 1'b0;
        #1;
        chk("midpass_reset_outputs", outs(), 160'(0));
        repeat (2) @(negedge Clk);
        chk("reset_held_outputs", outs(), 160'(0));
        Rst = 1'b1;
        @(negedge Clk);
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("after_reset");
        chk("after_reset_done_cycles", 160'(dc), 160'(81));
        repeat (2) @(negedge Clk);

        // Column index out of range: beat emitted with vval 0
        setup_basic();
        mem[2951] = 99999;
        mem[100001] = 55;
        exp_q[1] = mk(0, 32, 0, 1'b1, 1'b0);
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("badcol");
        repeat (3) @(negedge Clk);
        chk("badcol_err_sticky", 160'(err), 160'(1));

        // Row pointers {5,3}: row 0 empty
        clear_mem();
        mem[4000] = 5;
        for (int r = 1; r <= 16; r++) mem[4000 + r] = 3;
        set_bases(4000, 5000, 6000, 7000, 5);
        exp_q.delete();
        for (int r = 0; r < 16; r++) exp_q.push_back(mk(r, 0, 0, 1'b1, 1'b1));
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("backptr");
        chk("backptr_err", 160'(err), 160'(1));
        repeat (2) @(negedge Clk);

        // csize 4 with row pointer 20: row 0 clamped to 4 nonzeros
        clear_mem();
        mem[4000] = 0;
        for (int r = 1; r <= 16; r++) mem[4000 + r] = 20;
        for (int k = 0; k < 4; k++) begin
            mem[5000 + k] = k;
            mem[6000 + k] = 200 + k;
            mem[7000 + k] = 300 + k;
        end
        set_bases(4000, 5000, 6000, 7000, 4);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 200 + k, 300 + k, k == 3, 1'b0));
        for (int r = 1; r < 16; r++) exp_q.push_back(mk(r, 0, 0, 1'b1, 1'b1));
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("clamp");
        chk("clamp_err", 160'(err), 160'(1));
        repeat (2) @(negedge Clk);

        // A clean pass clears the sticky error
        setup_basic();
        run_pass(-1, 0, 0, fv, dc);
        cmp_beats("clean");
        chk("err_cleared", 160'(err), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hht_csr_sequencer.md
# hht_csr_sequencer

Fetch sequencer for the HHT sparse matrix–vector engine. It walks a CSR matrix held in memory (row pointers, column indices, nonzero values) together with the dense vector. It drives the two shared read ports (`addr1`/`dataIn1` for index data, `addr2`/`dataIn2` for value data) and emits one `(row, mval, vval)` beat per nonzero to the downstream multiply-accumulate stage over a valid/ready handshake. It replaces ad-hoc address stepping in `control` with a single FSM that owns both memory ports.

## Interface
- `N_ROWS`, 16: matrix rows; row-pointer table has `N_ROWS+1` entries.
- `N_COLS`, 16: dense vector length; valid column indices are `0..N_COLS-1`.
- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- `row_base`, `wdata_col_base`, `matrix_base`, `v_values_base`  in  32 each  base addresses; latched on accepted `start`.
- `csize`  in  32  total nonzero count; latched on accepted `start`.
- `addr1`  out  32  index port address (row pointers, column indices).
- `dataIn1`  in  32  combinational read data for `addr1`, valid in the same cycle.
- `addr2`  out  32  value port address (matrix values, vector values).
- `dataIn2`  in  32  combinational read data for `addr2`.
- `elem_valid`  out  1  output beat valid.
- `elem_ready`  in  1  consumer accepts the beat.
- `elem_row`  out  $clog2(N_ROWS)  row of the beat.
- `elem_mval`, `elem_vval`  out  32 each  matrix value and vector value.
- `elem_last`  out  1  last beat of the row.
- `elem_empty`  out  1  row has no nonzeros; mval and vval are 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `err`  out  1  sticky format-error flag; cleared by reset or accepted `start`.

## Operation
- States: IDLE, RP0, RP1, COL, VEC, OUT, DONE.
- Addresses:
  - `addr1` and `addr2` are registered and present for the whole state that uses them.
  - `dataIn` is captured at the edge that ends that state.
  - Addresses hold their last value otherwise.
  - Sums are 32-bit, modulo 2^32.
- IDLE → RP0 on `start`. The edge latches bases and `csize`, and sets `row=0`, `err=0`.
- RP0: `addr1=row_base`. Capture `p_start`. → RP1.
- RP1: `addr1=row_base+row+1`. Capture `p_end` and set `k=p_start`.
  - If `p_end<=p_start`: → OUT as an empty beat.
  - Otherwise → COL.
- COL: `addr1=wdata_col_base+k` and `addr2=matrix_base+k` in parallel. Capture `col` and `mval`. → VEC.
- VEC: `addr2=v_values_base+col`. Capture `vval`. → OUT.
- OUT: `elem_valid=1`, with `elem_last=(k+1==p_end)` or the row is empty.
  - Outputs are stable until `elem_ready`.
  - On accept, if not last: `k++` and → COL.
  - On accept, if last and `row==N_ROWS-1`: → DONE.
  - On accept, if last and not the final row: `row++`, `p_start=p_end`, → RP1. Row pointers are reused, so each row pointer is read once.
- DONE: `done=1` for one cycle. → IDLE.
- Error conditions (set `err`, processing continues):
  - `p_end<p_start`: the row is emitted as empty.
  - `p_end>csize`: `p_end` is clamped to `csize`.
  - `col>=N_COLS`: VEC is skipped and `vval=0`; the beat is still emitted.
- `start` while busy is ignored.
- Reset mid-pass: all state is discarded asynchronously. Return to IDLE with no further beats; the consumer discards any partial row.

## Timing
- Reset values: `addr1=addr2=0`, `elem_*=0`, `elem_valid=0`, `busy=0`, `done=0`, `err=0`. State is IDLE.
- Let E0 be the edge that samples `start`.
  - `busy` is high after E0.
  - The first `elem_valid` is high after E4 (RP0, RP1, COL, VEC).
- Per nonzero: 3 cycles with `elem_ready` held high (COL, VEC, OUT).
- Per row: +1 cycle (RP1). An empty row costs 2 cycles (RP1, OUT).
- Each cycle `elem_ready` is low in OUT adds 1 cycle. No beat is dropped or duplicated.
- `done` rises one edge after the final beat's accept edge. `busy` falls on the following edge.
- With ready always high, cycles from E0 to the `done` edge = 2 + Σ_rows(1 + max(3·nnz_r, 1)).

## Test plan
- Basic row, with `row_base=31550` holding rowptr {0,2,2,…}, `wdata_col_base=2950` holding col {0,5}, `matrix_base=90` holding {31,32}, and `v_values_base=2` holding v[0]=82, v[5]=93:
  - First beat: row0, mval 31, vval 82, last 0.
  - Second beat: row0, mval 32, vval 93, last 1.
  - Third beat: row1 with empty=1 and last=1.
- Back-pressure: `elem_ready` low for 5 cycles on beat 1 → outputs held constant. No address change on either port while in OUT. Beat count is unchanged.
- Full 16×16 pass with 20 nonzeros and ready always high → exactly 20 nonempty beats plus one beat per empty row. Rows are in order 0..15. `done` occurs 2+16+60+(empty rows) cycles after E0. `err=0`.
- Errors, each in its own pass; `err` stays 1 until the next `start`:
  - col index 99999 → beat emitted with vval 0, `err=1`.
  - rowptr {5,3} → row emitted as empty, `err=1`.
  - `csize=4` with final rowptr 20 → row clamped at k=4, `err=1`.
- Reset mid-pass: assert `Rst` low during row 3 → outputs return to reset values immediately. A fresh `start` reproduces the full-pass beat sequence.
- `start` pulsed while busy → ignored. Beat sequence and `done` timing are identical to the undisturbed run.
